// File: rtl/mmio_initiator_if.sv
// rtl/mmio_initiator_if.sv - command, response and responder-bus signal bundle for mmio_initiator
interface mmio_initiator_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // responder bus
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  // initiator side
  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready, rdata, ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, valid, addr, wmask, wdata
  );

  // environment side: command source, response sink and bus responder
  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready, rdata, ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, valid, addr, wmask, wdata
  );
endinterface

// File: rtl/mmio_initiator.sv
// rtl/mmio_initiator.sv - single-outstanding MMIO bus initiator with timeout and illegal-write detection
module mmio_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  mmio_initiator_if.master m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_t;

  // Counter value on the last BUS cycle allowed before the timeout fires.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  // All handshake outputs decode from registered state only, so there is
  // no combinational path from cmd_valid to cmd_ready.
  assign m.cmd_ready = (state_q == IDLE);
  assign m.valid     = (state_q == BUS);
  assign m.rsp_valid = (state_q == RSP);
  assign m.addr      = addr_q;
  assign m.wmask     = wmask_q;
  assign m.wdata     = wdata_q;
  assign m.rsp_rdata = rdata_q;
  assign m.rsp_err   = err_q;

  // Next-state and datapath: accept, run one bus transfer, hold the response.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (m.cmd_valid) begin
          if (m.cmd_we && (m.cmd_wmask == 4'b0000)) begin
            // A write with no byte enabled cannot be expressed on the bus
            // (wmask 0 means read), so it is rejected without a transfer.
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = RSP;
          end else begin
            addr_d  = m.cmd_addr;
            wdata_d = m.cmd_wdata;
            wmask_d = m.cmd_we ? m.cmd_wmask : 4'b0000;
            cnt_d   = 16'd0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // ready is checked first so a completion on the timeout cycle wins
        if (m.ready) begin
          rdata_d = (wmask_q == 4'b0000) ? m.rdata : 32'd0;
          err_d   = 1'b0;
          state_d = RSP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RSP: begin
        if (m.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wmask_q <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
